load_unit: RTL and testbench
============================

// Module: load_unit
// PURPOSE
//  Load-side data path between the core and data memory: takes one load (address + funct3)
//  per handshake, issues a word-aligned read, then extracts the addressed byte/halfword/word
//  with sign or zero extension (LB/LH/LW/LBU/LHU). Inverse of the store formatter.
//  Rejects misaligned or illegal loads without touching memory. Bounds memory latency with a timeout.
// PARAMETERS
//  TIMEOUT   16   max cycles in WAIT without mem_rvalid before error response (>=2)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   load request valid
//  req_ready   out  1   unit can accept request (high only in IDLE)
//  req_addr    in   32  byte address
//  req_funct3  in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  mem_req     out  1   memory read request, held until mem_gnt
//  mem_addr    out  32  {addr[31:2],2'b00}, stable while mem_req=1
//  mem_gnt     in   1   memory accepted request
//  mem_rvalid  in   1   read data valid (single-cycle pulse)
//  mem_rdata   in   32  read word, little-endian
//  rsp_valid   out  1   result valid, held until rsp_ready
//  rsp_ready   in   1   consumer accepts result
//  rsp_data    out  32  extended load result (0 when rsp_err=1)
//  rsp_err     out  1   misaligned, illegal funct3, or timeout
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0,
//   timeout counter=0. req_ready=1 in the first cycle after reset.
//  FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on error.
//  IDLE: req_ready=1. On req_valid: latch addr, funct3.
//   funct3 in {011,110,111} or LH/LHU with addr[0]=1 or LW with addr[1:0]!=0
//   -> RESP with rsp_err=1, rsp_data=0; mem_req never asserted. Otherwise -> REQ.
//  REQ: mem_req=1, mem_addr word-aligned; on mem_gnt -> WAIT, counter cleared.
//  WAIT: counter++ each cycle. mem_rvalid -> capture formatted data -> RESP, err=0.
//   counter==TIMEOUT-1 with no mem_rvalid -> RESP, rsp_err=1, rsp_data=0.
//   mem_rvalid on the timeout cycle wins (normal response).
//  RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_ready; on rsp_ready -> IDLE.
//   No new request accepted in the handoff cycle (req_ready=0 in RESP).
//  Extraction (off = addr[1:0]): byte = rdata[8*off +: 8]; half = rdata[16*addr[1] +: 16].
//   LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes word.
//  mem_rvalid outside WAIT is ignored (stale response after reset/timeout).
//  Minimum latency (gnt and rvalid immediate): accept cycle N, mem_req N+1, gnt N+1,
//   rvalid N+2, rsp_valid N+3. Error path: rsp_valid at N+1.
//  rst in any state: next cycle IDLE, outstanding transaction dropped, no response emitted.
// TESTING
//  LB @0x103, word 0x80FF1234 -> 0xFFFFFF80; LBU same -> 0x00000080; LB @0x101 -> 0x00000012.
//  LH @0x102, word 0x80017FFF -> 0xFFFF8001; LHU -> 0x00008001; LH @0x100 -> 0x00007FFF.
//  LW @0x101 and funct3=011 @0x100 -> rsp_err=1, rsp_data=0 at N+1, mem_req stays 0.
//  gnt delayed 3 cycles, rvalid 5 cycles after gnt, rsp_ready low 4 cycles -> mem_req/addr
//   held stable, single response, rsp_data stable until accepted, then req_ready=1.
//  No rvalid after gnt -> rsp_err=1 after exactly TIMEOUT WAIT cycles; later rvalid ignored.
//  rst asserted in WAIT -> next cycle IDLE, rsp_valid=0; following rvalid produces no response.

Source files
------------

// File: rtl/load_unit_if.sv
// Bundles the request, memory and response channels of the load unit.
// slave is the load unit's view; master is the core/memory side driving it.
interface load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_addr, req_funct3, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_addr, req_funct3, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/load_unit.sv
// Load-side data path: one load per handshake, word-aligned memory read, byte/half/word
// extraction with sign/zero extension, early rejection of illegal loads, bounded wait.
module load_unit #(
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst,
  load_unit_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off;
  logic [2:0]       funct3;
  logic [31:0]      mem_addr;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             accept;
  logic             bad;
  logic             timeout;

  function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3)
      3'b000, 3'b100: r = 1'b0;
      3'b001, 3'b101: r = a[0];
      3'b010:         r = |a;
      default:        r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] a,
                                          input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    bad     = is_illegal(bus.req_funct3, bus.req_addr[1:0]);
    timeout = (cnt == CNT_W'(TIMEOUT - 1));
    case (state)
      S_IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        state_d = bad ? S_RESP : S_REQ;
      end
      S_REQ:  if (bus.mem_gnt) state_d = S_WAIT;
      // rvalid on the final wait cycle still counts as a normal response
      S_WAIT: if (bus.mem_rvalid || timeout) state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      off      <= '0;
      funct3   <= '0;
      mem_addr <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        off      <= bus.req_addr[1:0];
        funct3   <= bus.req_funct3;
        mem_addr <= {bus.req_addr[31:2], 2'b00};
        if (bad) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state == S_REQ && bus.mem_gnt) cnt <= '0;
      if (state == S_WAIT) begin
        cnt <= cnt + 1'b1;
        if (bus.mem_rvalid) begin
          rsp_data <= extract(bus.mem_rdata, off, funct3);
          rsp_err  <= 1'b0;
        end else if (timeout) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.mem_req   = (state == S_REQ);
  assign bus.mem_addr  = mem_addr;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed and random loads drive the unit and a scripted memory;
// a monitor compares every accepted response against a queue filled by a reference model.
module tb_load_unit;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_unit_if bus ();
  load_unit #(.TIMEOUT(TIMEOUT)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  rsp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Reference: legality and extraction from shifts and plain integer arithmetic
  function automatic rsp_t model(input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [31:0] word);
    int   off, b, h, v;
    rsp_t r;
    off    = int'(addr % 32'd4);
    r.err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
             (((f3 == 3'd1) || (f3 == 3'd5)) && (off % 2 != 0)) ||
             ((f3 == 3'd2) && (off != 0));
    r.data = 32'd0;
    if (r.err) return r;
    b = int'((word >> (8 * off)) & 32'h000000FF);
    h = int'((word >> (16 * (off / 2))) & 32'h0000FFFF);
    case (f3)
      3'd0:    v = (b >= 128)   ? b - 256   : b;
      3'd1:    v = (h >= 32768) ? h - 65536 : h;
      3'd4:    v = b;
      3'd5:    v = h;
      default: v = int'(word);
    endcase
    r.data = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.mem_rdata = $urandom;
  endtask

  // One complete load: request, memory behaviour, response backpressure
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                         input int gdly, input int vdly, input bit drop, input int rdly,
                         input rsp_t exp);
    int          n;
    bit          bad;
    logic [31:0] aligned;
    rsp_t        m;
    m       = model(addr, f3, word);
    bad     = m.err;
    aligned = {addr[31:2], 2'b00};
    n = 0;
    while (!bus.req_ready && n < 50) begin
      step();
      n++;
    end
    check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    exp_q.push_back(exp);
    step();
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_funct3 = 3'($urandom);
    if (bad) begin
      check("err_mem_req", {31'b0, bus.mem_req}, 32'd0);
      check("err_latency", {31'b0, bus.rsp_valid}, 32'd1);
    end else begin
      check("mem_req_up", {31'b0, bus.mem_req}, 32'd1);
      check("mem_addr", bus.mem_addr, aligned);
      repeat (gdly) begin
        step();
        check("mem_req_hold", {31'b0, bus.mem_req}, 32'd1);
        check("mem_addr_hold", bus.mem_addr, aligned);
      end
      bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
      check("mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
      if (drop) begin
        n = 0;
        while (!bus.rsp_valid && n < TIMEOUT + 8) begin
          step();
          n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
      end else begin
        repeat (vdly) step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = word;
        step();
        bus.mem_rvalid = 1'b0;
        check("rsp_latency", {31'b0, bus.rsp_valid}, 32'd1);
      end
    end
    repeat (rdly) begin
      check("rsp_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("mem_req_resp", {31'b0, bus.mem_req}, 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("idle_after", {31'b0, bus.req_ready}, 32'd1);
    check("rsp_valid_clear", {31'b0, bus.rsp_valid}, 32'd0);
    if (drop && !bad) begin
      bus.mem_rvalid = 1'b1;
      step();
      bus.mem_rvalid = 1'b0;
      check("late_rvalid_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("late_rvalid_busy", {31'b0, bus.busy}, 32'd0);
    end
  endtask

  // Monitor: pops on every response handshake, checks stability while held
  initial begin
    rsp_t got, want, prev;
    bit   have_prev;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      got.err  = bus.rsp_err;
      got.data = bus.rsp_data;
      if (rst || !bus.rsp_valid) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          check("rsp_stable_data", got.data, prev.data);
          check("rsp_stable_err", {31'b0, got.err}, {31'b0, prev.err});
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_rsp: got data 0x%08h err %0d, required no response",
                     got.data, got.err);
          end else begin
            want = exp_q.pop_front();
            check("rsp_data", got.data, want.data);
            check("rsp_err", {31'b0, got.err}, {31'b0, want.err});
          end
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev      = got;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3_tab [8];
    logic [31:0] addr, word;
    logic [2:0]  f3;
    bit          drop;
    rsp_t        e;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_data", bus.rsp_data, 32'd0);
    check("reset_rsp_err", {31'b0, bus.rsp_err}, 32'd0);

    do_load(32'h103, 3'd0, 32'h80FF1234, 0, 0, 1'b0, 0, '{1'b0, 32'hFFFFFF80});
    do_load(32'h103, 3'd4, 32'h80FF1234, 0, 0, 1'b0, 0, '{1'b0, 32'h00000080});
    do_load(32'h101, 3'd0, 32'h80FF1234, 0, 0, 1'b0, 0, '{1'b0, 32'h00000012});
    do_load(32'h102, 3'd1, 32'h80017FFF, 0, 0, 1'b0, 0, '{1'b0, 32'hFFFF8001});
    do_load(32'h102, 3'd5, 32'h80017FFF, 0, 0, 1'b0, 0, '{1'b0, 32'h00008001});
    do_load(32'h100, 3'd1, 32'h80017FFF, 0, 0, 1'b0, 0, '{1'b0, 32'h00007FFF});
    do_load(32'h101, 3'd2, 32'h12345678, 0, 0, 1'b0, 0, '{1'b1, 32'h00000000});
    do_load(32'h100, 3'd3, 32'h12345678, 0, 0, 1'b0, 0, '{1'b1, 32'h00000000});
    do_load(32'h104, 3'd2, 32'hDEADBEEF, 3, 5, 1'b0, 4, '{1'b0, 32'hDEADBEEF});
    do_load(32'h108, 3'd2, 32'hCAFEF00D, 1, 0, 1'b1, 2, '{1'b1, 32'h00000000});

    for (int i = 0; i < 80; i++) begin
      addr = $urandom;
      word = $urandom;
      f3   = f3_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) f3 = 3'($urandom);
      drop = ($urandom_range(0, 9) == 0);
      e    = model(addr, f3, word);
      if (drop && !e.err) e = '{1'b1, 32'h00000000};
      do_load(addr, f3, word, $urandom_range(0, 3), $urandom_range(0, 6), drop,
              $urandom_range(0, 3), e);
    end

    // Reset while waiting on memory: transaction dropped, late data ignored
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h200;
    bus.req_funct3 = 3'd2;
    step();
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    step();
    check("wait_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_wait_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_wait_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_wait_req_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (3) begin
      check("rst_stale_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      step();
    end
    bus.rsp_ready = 1'b0;

    do_load(32'h301, 3'd4, 32'hA5B6C7D8, 0, 0, 1'b0, 1, '{1'b0, 32'h000000C7});
    repeat (2) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
